// File: rtl/bs_arb.sv
// Round-robin arbiter sharing one barrel shifter (bs) between N requesters.
// Define BS_ARB_SKID_EN for a 2-entry output buffer that removes the rsp_rdy_i -> req_rdy_o path.

module bs #(
  parameter int W       = 32,
  parameter int SHIFT_W = $clog2(W)
) (
  input  logic [W-1:0]       i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_is_arith,
  input  logic               i_is_rotate,
  input  logic               i_is_right,
  output logic [W-1:0]       o_y
);

  logic [W-1:0]             w_in;
  logic [SHIFT_W:0][W-1:0]  w_stage;
  logic                     w_fill;

  // Left operations reuse the right-shifting stages by bit-reversing in and out.
  assign w_fill = i_is_arith & i_is_right & ~i_is_rotate & i_x[W-1];

  always_comb begin
    w_in = '0;
    for (int b = 0; b < W; b++) begin
      w_in[b] = i_is_right ? i_x[b] : i_x[W-1-b];
    end
  end

  assign w_stage[0] = w_in;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int AMT = 1 << k;
    logic [W-1:0] w_shifted;

    for (genvar b = 0; b < W; b++) begin : g_bit
      if (b + AMT < W) begin : g_in
        assign w_shifted[b] = w_stage[k][b+AMT];
      end else begin : g_wrap
        assign w_shifted[b] = i_is_rotate ? w_stage[k][(b+AMT)%W] : w_fill;
      end
    end

    assign w_stage[k+1] = i_shift[k] ? w_shifted : w_stage[k];
  end

  always_comb begin
    o_y = '0;
    for (int b = 0; b < W; b++) begin
      o_y[b] = i_is_right ? w_stage[SHIFT_W][b] : w_stage[SHIFT_W][W-1-b];
    end
  end

endmodule

module bs_arb #(
  parameter int W       = 32,
  parameter int N       = 4,
  parameter int SHIFT_W = $clog2(W),
  parameter int ID_W    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_vld_i,
  output logic [N-1:0]         req_rdy_o,
  input  logic [N*W-1:0]       req_x_i,
  input  logic [N*SHIFT_W-1:0] req_shift_i,
  input  logic [N*3-1:0]       req_op_i,
  output logic                 rsp_vld_o,
  input  logic                 rsp_rdy_i,
  output logic [W-1:0]         rsp_y_o,
  output logic [ID_W-1:0]      rsp_id_o
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_BOTH
  } state_t;

  state_t            r_state;
  state_t            w_stateNxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   w_grant;
  logic              w_anyVld;
  logic              w_canAccept;
  logic              w_accept;
  logic              w_pop;
  logic              w_loadMain;
  logic [W-1:0]      w_selX;
  logic [SHIFT_W-1:0] w_selShift;
  logic [2:0]        w_selOp;
  logic [W-1:0]      w_bsY;
  logic [W-1:0]      r_y;
  logic [ID_W-1:0]   r_id;
`ifdef BS_ARB_SKID_EN
  logic              w_loadSkid;
  logic              w_mainFromSkid;
  logic [W-1:0]      r_skY;
  logic [ID_W-1:0]   r_skId;
`endif

  function automatic logic [ID_W-1:0] wrapInc(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return ID_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    w_grant  = '0;
    w_anyVld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vld_i[wrapInc(r_ptr, i)]) begin
        w_grant  = wrapInc(r_ptr, i);
        w_anyVld = 1'b1;
      end
    end
  end

`ifdef BS_ARB_SKID_EN
  assign w_canAccept = (r_state != ST_BOTH);
`else
  assign w_canAccept = (r_state == ST_EMPTY) | rsp_rdy_i;
`endif

  always_comb begin
    req_rdy_o = '0;
    if (!rst && w_anyVld && w_canAccept) begin
      req_rdy_o[w_grant] = 1'b1;
    end
  end

  assign w_accept = |(req_vld_i & req_rdy_o);
  assign w_pop    = rsp_vld_o & rsp_rdy_i;

  assign w_selX     = req_x_i[w_grant*W +: W];
  assign w_selShift = req_shift_i[w_grant*SHIFT_W +: SHIFT_W];
  assign w_selOp    = req_op_i[w_grant*3 +: 3];

  bs #(
    .W       (W),
    .SHIFT_W (SHIFT_W)
  ) u_bs (
    .i_x         (w_selX),
    .i_shift     (w_selShift),
    .i_is_arith  (w_selOp[2]),
    .i_is_rotate (w_selOp[1]),
    .i_is_right  (w_selOp[0]),
    .o_y         (w_bsY)
  );

`ifdef BS_ARB_SKID_EN
  // A new command lands in the skid slot only while the main entry is stuck.
  always_comb begin
    w_stateNxt     = r_state;
    w_loadMain     = 1'b0;
    w_loadSkid     = 1'b0;
    w_mainFromSkid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_loadMain = 1'b1;
          w_stateNxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          if (w_accept) w_loadMain = 1'b1;
          else          w_stateNxt = ST_EMPTY;
        end else if (w_accept) begin
          w_loadSkid = 1'b1;
          w_stateNxt = ST_BOTH;
        end
      end
      ST_BOTH: begin
        if (w_pop) begin
          w_mainFromSkid = 1'b1;
          w_stateNxt     = ST_FULL;
        end
      end
      default: w_stateNxt = ST_EMPTY;
    endcase
  end
`else
  always_comb begin
    w_stateNxt = r_state;
    w_loadMain = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_loadMain = 1'b1;
          w_stateNxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_accept)   w_loadMain = 1'b1;
        else if (w_pop) w_stateNxt = ST_EMPTY;
      end
      default: w_stateNxt = ST_EMPTY;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_stateNxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_y    <= '0;
      r_id   <= '0;
`ifdef BS_ARB_SKID_EN
      r_skY  <= '0;
      r_skId <= '0;
`endif
    end else begin
      if (w_accept) r_ptr <= wrapInc(w_grant, 1);
      if (w_loadMain) begin
        r_y  <= w_bsY;
        r_id <= w_grant;
      end
`ifdef BS_ARB_SKID_EN
      if (w_mainFromSkid) begin
        r_y  <= r_skY;
        r_id <= r_skId;
      end
      if (w_loadSkid) begin
        r_skY  <= w_bsY;
        r_skId <= w_grant;
      end
`endif
    end
  end

  assign rsp_vld_o = (r_state != ST_EMPTY);
  assign rsp_y_o   = r_y;
  assign rsp_id_o  = r_id;

endmodule

// File: tb/tb_bs_arb.sv
// Self-checking bench for bs_arb: round-robin model plus result scoreboard.
// Build with BS_ARB_SKID_EN defined to check the skid-buffer variant.

module tb_bs_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 5;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] y;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_vld_i;
  logic [N-1:0]  req_rdy_o;
  logic [N*W-1:0]  req_x_i;
  logic [N*SW-1:0] req_shift_i;
  logic [N*3-1:0]  req_op_i;
  logic          rsp_vld_o;
  logic          rsp_rdy_i;
  logic [W-1:0]  rsp_y_o;
  logic [1:0]    rsp_id_o;

  logic [31:0] cmdX  [N];
  logic [4:0]  cmdSh [N];
  logic [2:0]  cmdOp [N];
  int          reqCnt [N];
  logic        rspRdy;
  logic        rstIn;
  int          mPtr;
  exp_t        expQ [$];
  int          nChecks;
  int          nPass;
  int          dutAccepts;

  bs_arb #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld_i   (req_vld_i),
    .req_rdy_o   (req_rdy_o),
    .req_x_i     (req_x_i),
    .req_shift_i (req_shift_i),
    .req_op_i    (req_op_i),
    .rsp_vld_o   (rsp_vld_o),
    .rsp_rdy_i   (rsp_rdy_i),
    .rsp_y_o     (rsp_y_o),
    .rsp_id_o    (rsp_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else nPass++;
  endtask

  function automatic logic [31:0] refShift(input logic [31:0] x, input logic [4:0] sh, input logic [2:0] op);
    logic [63:0] dbl;
    dbl = {x, x};
    if (op[1]) begin
      if (op[0]) begin
        dbl = dbl >> sh;
        return dbl[31:0];
      end
      dbl = dbl << sh;
      return dbl[63:32];
    end
    if (op[0]) return op[2] ? 32'($signed(x) >>> sh) : (x >> sh);
    return x << sh;
  endfunction

  task automatic newCmd(input int k);
    cmdX[k]  = $urandom;
    cmdSh[k] = 5'($urandom_range(0, 31));
    cmdOp[k] = 3'($urandom_range(0, 7));
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus();
    logic [N-1:0] expRdy;
    logic         canAcc;
    logic         any;
    int           g;
    exp_t         e;
    for (int k = 0; k < N; k++) begin
      req_vld_i[k]            = (reqCnt[k] > 0);
      req_x_i[k*W +: W]       = cmdX[k];
      req_shift_i[k*SW +: SW] = cmdSh[k];
      req_op_i[k*3 +: 3]      = cmdOp[k];
    end
    rst       = rstIn;
    rsp_rdy_i = rspRdy;
    #1;
`ifdef BS_ARB_SKID_EN
    canAcc = (expQ.size() < 2);
`else
    canAcc = (expQ.size() == 0) || rspRdy;
`endif
    any = 1'b0;
    g   = 0;
    for (int i = 0; i < N; i++) begin
      if (!any && reqCnt[(mPtr + i) % N] > 0) begin
        any = 1'b1;
        g   = (mPtr + i) % N;
      end
    end
    expRdy = '0;
    if (!rstIn && any && canAcc) expRdy[g] = 1'b1;
    checkOutput("reqRdy", req_rdy_o, expRdy);
    checkOutput("rspVld", rsp_vld_o, expQ.size() > 0);
    if (expQ.size() > 0) begin
      checkOutput("rspY", rsp_y_o, expQ[0].y);
      checkOutput("rspId", rsp_id_o, expQ[0].id);
    end
    if (|(req_vld_i & req_rdy_o)) dutAccepts++;
    if (rstIn) begin
      expQ.delete();
      mPtr = 0;
    end else begin
      if (expQ.size() > 0 && rspRdy) void'(expQ.pop_front());
      if (expRdy != '0) begin
        e.id = 2'(g);
        e.y  = refShift(cmdX[g], cmdSh[g], cmdOp[g]);
        expQ.push_back(e);
        mPtr = (g + 1) % N;
        reqCnt[g]--;
        if (reqCnt[g] > 0) newCmd(g);
      end
    end
    @(negedge clk);
  endtask

  task automatic setCmd(input int k, input logic [31:0] x, input logic [4:0] sh, input logic [2:0] op);
    cmdX[k]   = x;
    cmdSh[k]  = sh;
    cmdOp[k]  = op;
    reqCnt[k] = 1;
  endtask

  int   seenIds [$];
  int   fairExp [6] = '{0, 1, 2, 3, 0, 1};
  int   expExtra;

  initial begin
    nChecks    = 0;
    nPass      = 0;
    dutAccepts = 0;
    mPtr       = 0;
    rstIn      = 1'b1;
    rspRdy     = 1'b1;
    rst        = 1'b1;
    rsp_rdy_i  = 1'b1;
    req_vld_i  = '0;
    req_x_i    = '0;
    req_shift_i = '0;
    req_op_i   = '0;
    for (int k = 0; k < N; k++) begin
      reqCnt[k] = 0;
      newCmd(k);
    end

    @(negedge clk);
    applyStimulus();
    checkOutput("rstY", rsp_y_o, 32'h0);
    checkOutput("rstId", rsp_id_o, 2'd0);
    rstIn = 1'b0;

    setCmd(0, 32'h8000_0001, 5'd4, 3'b101);
    applyStimulus();
    checkOutput("arsVld", rsp_vld_o, 1'b1);
    checkOutput("arsY", rsp_y_o, 32'hF800_0000);
    checkOutput("arsId", rsp_id_o, 2'd0);

    setCmd(1, 32'h1234_5678, 5'd0, 3'b000);
    setCmd(2, 32'h8000_0001, 5'd1, 3'b010);
    setCmd(3, 32'h8000_0000, 5'd31, 3'b001);
    applyStimulus();
    checkOutput("zeroY", rsp_y_o, 32'h1234_5678);
    checkOutput("zeroId", rsp_id_o, 2'd1);
    applyStimulus();
    checkOutput("rotlY", rsp_y_o, 32'h0000_0003);
    checkOutput("rotlId", rsp_id_o, 2'd2);
    applyStimulus();
    checkOutput("lsrY", rsp_y_o, 32'h0000_0001);
    checkOutput("lsrId", rsp_id_o, 2'd3);
    applyStimulus();

    for (int k = 0; k < N; k++) begin
      newCmd(k);
      reqCnt[k] = 2;
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      checkOutput("fairVld", rsp_vld_o, 1'b1);
      seenIds.push_back(int'(rsp_id_o));
    end
    for (int i = 0; i < 6; i++) checkOutput("fairOrder", seenIds[i], fairExp[i]);
    applyStimulus();

    for (int k = 0; k < N; k++) begin
      newCmd(k);
      reqCnt[k] = 3;
    end
    applyStimulus();
    rspRdy     = 1'b0;
    dutAccepts = 0;
    for (int c = 0; c < 3; c++) applyStimulus();
`ifdef BS_ARB_SKID_EN
    expExtra = 1;
`else
    expExtra = 0;
`endif
    checkOutput("bpAccepts", dutAccepts, expExtra);
    rspRdy = 1'b1;
    for (int c = 0; c < 6; c++) applyStimulus();
    for (int k = 0; k < N; k++) reqCnt[k] = 0;
    for (int c = 0; c < 3; c++) applyStimulus();

    newCmd(2);
    reqCnt[2] = 1;
    applyStimulus();
    setCmd(1, 32'hF0F0_0000, 5'd8, 3'b011);
    applyStimulus();
    checkOutput("dnaVld", rsp_vld_o, 1'b1);
    checkOutput("dnaId", rsp_id_o, 2'd1);
    checkOutput("dnaY", rsp_y_o, 32'h00F0_F000);
    applyStimulus();

    for (int k = 0; k < N; k++) begin
      newCmd(k);
      reqCnt[k] = 2;
    end
    rspRdy = 1'b0;
    applyStimulus();
    applyStimulus();
    rstIn = 1'b1;
    applyStimulus();
    checkOutput("midRstVld", rsp_vld_o, 1'b0);
    rstIn = 1'b0;
    rspRdy = 1'b1;
    reqCnt[0] = 0;
    reqCnt[1] = 1;
    reqCnt[2] = 0;
    reqCnt[3] = 1;
    applyStimulus();
    checkOutput("postRstId", rsp_id_o, 2'd1);
    applyStimulus();
    checkOutput("postRstId2", rsp_id_o, 2'd3);
    applyStimulus();

    for (int c = 0; c < 80; c++) begin
      for (int k = 0; k < N; k++) begin
        if (reqCnt[k] == 0 && $urandom_range(0, 2) == 0) begin
          newCmd(k);
          reqCnt[k] = 1;
        end
      end
      rspRdy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    for (int k = 0; k < N; k++) reqCnt[k] = 0;
    rspRdy = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus();

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
